// File: rtl/quadrature_encoder.sv
// x4 quadrature decoder: synchronises A/B, detects each legal phase step and
// keeps a 16-bit position count that wraps modulo ENCODER_MAX.
module quadrature_encoder #(
    parameter int ENCODER_MAX = 64000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        A,
    input  logic        B,
    output logic [15:0] count
);

    localparam logic [15:0] CNT_TOP = 16'(ENCODER_MAX - 1);

    logic [1:0]        ab_s1;
    logic [1:0]        ab_s2;
    logic [1:0]        ab_prev;
    logic signed [1:0] dir;

    // +1 for a forward step, -1 for a reverse step, 0 for hold or a double-bit jump.
    function automatic logic signed [1:0] decode_step(input logic [1:0] prv,
                                                      input logic [1:0] cur);
        case ({prv, cur})
            4'b0001, 4'b0111, 4'b1110, 4'b1000: return 2'sd1;
            4'b0010, 4'b1011, 4'b1101, 4'b0100: return -2'sd1;
            default:                            return 2'sd0;
        endcase
    endfunction

    function automatic logic [15:0] wrap_inc(input logic [15:0] c);
        return (c == CNT_TOP) ? 16'd0 : c + 16'd1;
    endfunction

    function automatic logic [15:0] wrap_dec(input logic [15:0] c);
        return (c == 16'd0) ? CNT_TOP : c - 16'd1;
    endfunction

    always_comb begin
        dir = decode_step(ab_prev, ab_s2);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ab_s1   <= 2'b00;
            ab_s2   <= 2'b00;
            ab_prev <= 2'b00;
            count   <= 16'd0;
        end else begin
            ab_s1   <= {A, B};
            ab_s2   <= ab_s1;
            ab_prev <= ab_s2;
            if (dir == 2'sd1) begin
                count <= wrap_inc(count);
            end else if (dir == -2'sd1) begin
                count <= wrap_dec(count);
            end
        end
    end

endmodule

// File: tb/tb_quadrature_encoder.sv
// Scoreboard bench for quadrature_encoder: a behavioural count model pushes
// the expected value for every driven state; it is popped three edges later.
module tb_quadrature_encoder;

    localparam int ENCODER_MAX = 64000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        A   = 1'b0;
    logic        B   = 1'b0;
    logic [15:0] count;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] sbq[$];
    int          model_cnt  = 0;
    logic [1:0]  model_prev = 2'b00;
    logic [1:0]  cur_ab     = 2'b00;

    quadrature_encoder #(.ENCODER_MAX(ENCODER_MAX)) dut (
        .clk   (clk),
        .rst   (rst),
        .A     (A),
        .B     (B),
        .count (count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: count=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_step(input logic [1:0] prv, input logic [1:0] cur);
        case ({prv, cur})
            4'b0001, 4'b0111, 4'b1110, 4'b1000: return 1;
            4'b0010, 4'b1011, 4'b1101, 4'b0100: return -1;
            default:                            return 0;
        endcase
    endfunction

    // Called at a negedge: retire the entry driven three negedges ago, then drive.
    task automatic tick(input logic [1:0] ab);
        if (sbq.size() == 3) check_eq("pipe", count, sbq.pop_front());
        A = ab[1];
        B = ab[0];
        cur_ab = ab;
        model_cnt = (model_cnt + model_step(model_prev, ab) + ENCODER_MAX) % ENCODER_MAX;
        model_prev = ab;
        sbq.push_back(16'(model_cnt));
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) tick(cur_ab);
    endtask

    task automatic apply_reset(input logic [1:0] ab, input int cycles);
        sbq.delete();
        A = ab[1];
        B = ab[0];
        cur_ab = ab;
        rst = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check_eq("reset_hold", count, 16'd0);
        end
        rst = 1'b0;
        model_cnt = 0;
        model_prev = 2'b00;
    endtask

    logic [1:0] fwd_seq[4];
    logic [1:0] rev_seq[4];

    initial begin
        int idx;
        int r;
        fwd_seq = '{2'b00, 2'b01, 2'b11, 2'b10};
        rev_seq = '{2'b00, 2'b10, 2'b11, 2'b01};

        // Reset with A=B=0
        apply_reset(2'b00, 2);
        drain();
        check_eq("after_reset", count, 16'd0);

        // Forward: 16 states starting at 00
        for (int c = 0; c < 4; c++)
            for (int s = 0; s < 4; s++) tick(fwd_seq[s]);
        drain();
        check_eq("fwd_final", count, 16'd15);

        // Reverse: 10->00 is +1, then 15 decrements
        for (int c = 0; c < 4; c++)
            for (int s = 0; s < 4; s++) tick(rev_seq[s]);
        drain();
        check_eq("rev_final", count, 16'd1);

        // 01->00 brings count to 0, then wrap down and back up
        tick(2'b00);
        drain();
        check_eq("at_zero", count, 16'd0);
        tick(2'b10);
        drain();
        check_eq("wrap_down", count, 16'd63999);
        tick(2'b00);
        drain();
        check_eq("wrap_up", count, 16'd0);

        // Illegal double-bit jumps are ignored
        tick(2'b11);
        drain();
        check_eq("illegal_00_11", count, 16'd0);
        tick(2'b00);
        drain();
        check_eq("illegal_11_00", count, 16'd0);
        tick(2'b01);
        tick(2'b10);
        drain();
        check_eq("illegal_01_10", count, 16'd1);

        // Random walk with holds and occasional illegal jumps
        idx = 2;
        for (int i = 0; i < 300; i++) begin
            r = int'($urandom_range(0, 11));
            if (r < 6)       idx = (idx + 1) % 4;
            else if (r < 9)  idx = (idx + 3) % 4;
            else if (r < 10) idx = (idx + 2) % 4;
            tick(fwd_seq[idx]);
        end
        drain();

        // Back to 00 cleanly, then build count to 15 for the async reset
        apply_reset(2'b00, 1);
        for (int s = 0; s < 16; s++) tick(fwd_seq[s % 4]);
        drain();
        check_eq("pre_async", count, 16'd15);

        // Async reset asserted between edges takes effect without a clock
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("async_reset", count, 16'd0);
        @(negedge clk);
        apply_reset(2'b01, 2);

        // Non-00 input held through reset registers as one step after release
        drain();
        check_eq("post_reset_step", count, 16'd1);

        // Illegal state held through reset registers as nothing
        apply_reset(2'b11, 2);
        drain();
        check_eq("post_reset_illegal", count, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
